// File: rtl/ofm_write_controller.sv
// Captures a full PE-array OFM row and writes it back to feature RAM as NUM_BEATS packed words.
// Optional macro OFM_WR_STALL_EN lets wr_ready stall beats; otherwise every SEND cycle is a write.
module ofm_write_controller #(
    parameter  int NUM_PE       = 16,
    parameter  int DATA_W       = 8,
    parameter  int LANES_PER_WR = 4,
    parameter  int ADDR_W       = 32,
    localparam int NUM_BEATS    = NUM_PE / LANES_PER_WR,
    localparam int SEL_W        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
    localparam int WORD_W       = LANES_PER_WR * DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_PE-1:0]        ofm_valid,
    input  logic [NUM_PE*DATA_W-1:0] ofm_data,
    output logic                     ofm_ready,
    input  logic                     layer_done,
    input  logic                     wr_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [WORD_W-1:0]        wr_data,
    output logic [SEL_W-1:0]         mux_sel,
    output logic                     row_done,
    output logic [15:0]              row_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(NUM_BEATS - 1);

    state_t                   state;
    logic [SEL_W-1:0]         beat;
    logic [ADDR_W-1:0]        addr;
    logic [NUM_PE*DATA_W-1:0] row_buf;
    logic                     accept;

`ifdef OFM_WR_STALL_EN
    assign accept = wr_en & wr_ready;
`else
    logic unused_wr_ready;
    assign unused_wr_ready = wr_ready;
    assign accept          = wr_en;
`endif

    assign wr_addr = addr;
    assign mux_sel = beat;
    assign wr_data = row_buf[int'(beat)*WORD_W +: WORD_W];

    // wr_en/ofm_ready are registered alongside state so no input reaches an output combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            addr      <= '0;
            row_buf   <= '0;
            row_cnt   <= '0;
            row_done  <= 1'b0;
            wr_en     <= 1'b0;
            ofm_ready <= 1'b1;
        end else begin
            row_done <= 1'b0;
            if (layer_done) begin
                state     <= IDLE;
                beat      <= '0;
                addr      <= '0;
                row_cnt   <= '0;
                wr_en     <= 1'b0;
                ofm_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (&ofm_valid) begin
                            row_buf   <= ofm_data;
                            beat      <= '0;
                            state     <= SEND;
                            wr_en     <= 1'b1;
                            ofm_ready <= 1'b0;
                        end
                    end
                    SEND: begin
                        if (accept) begin
                            addr <= addr + 1'b1;
                            // beat returns to 0 so mux_sel reads 0 while idle
                            if (beat == LAST_BEAT) begin
                                beat      <= '0;
                                state     <= IDLE;
                                row_done  <= 1'b1;
                                row_cnt   <= row_cnt + 16'd1;
                                wr_en     <= 1'b0;
                                ofm_ready <= 1'b1;
                            end else begin
                                beat <= beat + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ofm_write_controller.sv
// Directed self-checking bench for ofm_write_controller (default build and ADDR_W=4 instance).
module tb_ofm_write_controller;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [15:0]  ofm_valid = '0;
    logic [127:0] ofm_data = '0;
    logic         layer_done = 1'b0;
    logic         wr_ready = 1'b1;

    logic         ofm_ready, wr_en, row_done;
    logic [31:0]  wr_addr, wr_data;
    logic [1:0]   mux_sel;
    logic [15:0]  row_cnt;

    logic         ofm_ready_w, wr_en_w, row_done_w;
    logic [3:0]   wr_addr_w;
    logic [31:0]  wr_data_w;
    logic [1:0]   mux_sel_w;
    logic [15:0]  row_cnt_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ofm_write_controller dut (
        .clk(clk), .rst_n(rst_n), .ofm_valid(ofm_valid), .ofm_data(ofm_data),
        .ofm_ready(ofm_ready), .layer_done(layer_done), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mux_sel(mux_sel),
        .row_done(row_done), .row_cnt(row_cnt)
    );

    ofm_write_controller #(.ADDR_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .ofm_valid(ofm_valid), .ofm_data(ofm_data),
        .ofm_ready(ofm_ready_w), .layer_done(layer_done), .wr_ready(wr_ready),
        .wr_en(wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w), .mux_sel(mux_sel_w),
        .row_done(row_done_w), .row_cnt(row_cnt_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int off);
        for (int i = 0; i < 16; i++) ofm_data[i*8 +: 8] = 8'(i + off);
    endtask

    function automatic logic [31:0] exp_word(input int off, input int b);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(off + b*4 + k);
        return w;
    endfunction

    task automatic clear_layer();
        layer_done = 1'b1;
        ofm_valid  = '0;
        wr_ready   = 1'b1;
        tick();
        layer_done = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ofm_ready !== 1'b1 || wr_en !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0 ||
            mux_sel !== 2'd0 || row_done !== 1'b0 || row_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b en=%b addr=%h data=%h sel=%0d done=%b cnt=%0d required 1 0 0 0 0 0 0",
                     ofm_ready, wr_en, wr_addr, wr_data, mux_sel, row_done, row_cnt);
        end
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_default_row();
        clear_layer();
        set_row(0);
        ofm_valid = 16'hFFFF;
        tick();
        ofm_valid = '0;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (wr_en !== 1'b1 || ofm_ready !== 1'b0 || wr_addr !== 32'(b) || mux_sel !== 2'(b) ||
                wr_data !== exp_word(0, b) || row_done !== 1'b0) begin
                n_fail++;
                $display("FAIL default_beat%0d: en=%b rdy=%b addr=%h sel=%0d data=%h done=%b required 1 0 %h %0d %h 0",
                         b, wr_en, ofm_ready, wr_addr, mux_sel, wr_data, row_done, b, b, exp_word(0, b));
            end
            tick();
        end
        n_checks++;
        if (row_done !== 1'b1 || ofm_ready !== 1'b1 || wr_en !== 1'b0 || row_cnt !== 16'd1 || mux_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL default_done: done=%b rdy=%b en=%b cnt=%0d sel=%0d required 1 1 0 1 0",
                     row_done, ofm_ready, wr_en, row_cnt, mux_sel);
        end
        tick();
        n_checks++;
        if (row_done !== 1'b0 || wr_addr !== 32'd4) begin
            n_fail++;
            $display("FAIL default_after: done=%b addr=%h required 0 4", row_done, wr_addr);
        end
    endtask

    task automatic test_partial_valid();
        clear_layer();
        set_row(16);
        ofm_valid = 16'h7FFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (wr_en !== 1'b0 || ofm_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL partial_idle%0d: en=%b rdy=%b required 0 1", i, wr_en, ofm_ready);
            end
        end
        ofm_valid = 16'hFFFF;
        tick();
        ofm_valid = '0;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 32'(b) || wr_data !== exp_word(16, b)) begin
                n_fail++;
                $display("FAIL partial_beat%0d: en=%b addr=%h data=%h required 1 %h %h",
                         b, wr_en, wr_addr, wr_data, b, exp_word(16, b));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        clear_layer();
        set_row(64);
        ofm_valid = 16'hFFFF;
        tick();
        ofm_valid = '0;
`ifdef OFM_WR_STALL_EN
        n_checks++;
        if (wr_addr !== 32'd0 || wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_beat0: addr=%h en=%b required 0 1", wr_addr, wr_en);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 32'd1 || mux_sel !== 2'd1 || wr_data !== exp_word(64, 1)) begin
                n_fail++;
                $display("FAIL stall_hold%0d: en=%b addr=%h sel=%0d data=%h required 1 1 1 %h",
                         i, wr_en, wr_addr, mux_sel, wr_data, exp_word(64, 1));
            end
            wr_ready = (i == 3);
            tick();
        end
        for (int b = 2; b < 4; b++) begin
            n_checks++;
            if (wr_addr !== 32'(b) || row_done !== 1'b0 || wr_en !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_beat%0d: addr=%h done=%b en=%b required %h 0 1", b, wr_addr, row_done, wr_en, b);
            end
            tick();
        end
        n_checks++;
        if (row_done !== 1'b1 || row_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_done: done=%b cnt=%0d required 1 1", row_done, row_cnt);
        end
`else
        wr_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 32'(b) || wr_data !== exp_word(64, b)) begin
                n_fail++;
                $display("FAIL nostall_beat%0d: en=%b addr=%h data=%h required 1 %h %h",
                         b, wr_en, wr_addr, wr_data, b, exp_word(64, b));
            end
            tick();
        end
        n_checks++;
        if (row_done !== 1'b1 || row_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL nostall_done: done=%b cnt=%0d required 1 1", row_done, row_cnt);
        end
        wr_ready = 1'b1;
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        clear_layer();
        set_row(128);
        ofm_valid = 16'hFFFF;
        tick();
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 32'(b) || wr_data !== exp_word(128, b)) begin
                n_fail++;
                $display("FAIL b2b_row0_beat%0d: en=%b addr=%h data=%h required 1 %h %h",
                         b, wr_en, wr_addr, wr_data, b, exp_word(128, b));
            end
            tick();
        end
        n_checks++;
        if (ofm_ready !== 1'b1 || wr_en !== 1'b0 || row_done !== 1'b1 || row_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_gap: rdy=%b en=%b done=%b cnt=%0d required 1 0 1 1", ofm_ready, wr_en, row_done, row_cnt);
        end
        tick();
        ofm_valid = '0;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 32'(b + 4) || mux_sel !== 2'(b)) begin
                n_fail++;
                $display("FAIL b2b_row1_beat%0d: en=%b addr=%h sel=%0d required 1 %h %0d",
                         b, wr_en, wr_addr, mux_sel, b + 4, b);
            end
            tick();
        end
        n_checks++;
        if (row_cnt !== 16'd2 || row_done !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_count: cnt=%0d done=%b required 2 1", row_cnt, row_done);
        end
    endtask

    task automatic test_layer_done();
        clear_layer();
        set_row(200);
        ofm_valid = 16'hFFFF;
        tick();
        ofm_valid = '0;
        repeat (4) tick();
        ofm_valid = 16'hFFFF;
        tick();
        ofm_valid = '0;
        tick();
        tick();
        n_checks++;
        if (wr_en !== 1'b1 || wr_addr !== 32'd6 || mux_sel !== 2'd2 || row_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL ld_third_beat: en=%b addr=%h sel=%0d cnt=%0d required 1 6 2 1", wr_en, wr_addr, mux_sel, row_cnt);
        end
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== 32'd0 || mux_sel !== 2'd0 || row_cnt !== 16'd0 ||
            row_done !== 1'b0 || ofm_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ld_clear: en=%b addr=%h sel=%0d cnt=%0d done=%b rdy=%b required 0 0 0 0 0 1",
                     wr_en, wr_addr, mux_sel, row_cnt, row_done, ofm_ready);
        end
        set_row(100);
        ofm_valid = 16'hFFFF;
        tick();
        ofm_valid = '0;
        for (int b = 0; b < 4; b++) begin
            n_checks++;
            if (wr_en !== 1'b1 || wr_addr !== 32'(b) || wr_data !== exp_word(100, b)) begin
                n_fail++;
                $display("FAIL ld_next_beat%0d: en=%b addr=%h data=%h required 1 %h %h",
                         b, wr_en, wr_addr, wr_data, b, exp_word(100, b));
            end
            tick();
        end
    endtask

    task automatic test_wrap_and_reset();
        clear_layer();
        set_row(8);
        ofm_valid = 16'hFFFF;
        tick();
        for (int r = 0; r < 5; r++) begin
            for (int b = 0; b < 4; b++) begin
                if (r == 4) ofm_valid = '0;
                n_checks++;
                if (wr_en_w !== 1'b1 || wr_addr_w !== 4'((r*4 + b) % 16)) begin
                    n_fail++;
                    $display("FAIL wrap_row%0d_beat%0d: en=%b addr=%h required 1 %h",
                             r, b, wr_en_w, wr_addr_w, (r*4 + b) % 16);
                end
                tick();
            end
            tick();
        end
        n_checks++;
        if (row_cnt_w !== 16'd5 || wr_addr_w !== 4'd4) begin
            n_fail++;
            $display("FAIL wrap_count: cnt=%0d addr=%h required 5 4", row_cnt_w, wr_addr_w);
        end
        ofm_valid = 16'hFFFF;
        tick();
        ofm_valid = '0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ofm_ready !== 1'b1 || wr_en !== 1'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0 ||
            mux_sel !== 2'd0 || row_done !== 1'b0 || row_cnt !== 16'd0 || wr_addr_w !== 4'd0 || wr_en_w !== 1'b0) begin
            n_fail++;
            $display("FAIL midrow_reset: rdy=%b en=%b addr=%h data=%h sel=%0d done=%b cnt=%0d addr_w=%h en_w=%b required 1 0 0 0 0 0 0 0 0",
                     ofm_ready, wr_en, wr_addr, wr_data, mux_sel, row_done, row_cnt, wr_addr_w, wr_en_w);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_default_row();
        test_partial_valid();
        test_backpressure();
        test_back_to_back();
        test_layer_done();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
